// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
// This block arbitrates two write requesters into one register-file write port.
// A clear sweep zeroes every row one per cycle after reset or on request.
// While the sweep runs the block reports Busy and grants nothing.
// While running, a single requester is granted at once. Two requesters
// alternate round-robin. Each granted write shows up on the registered
// WriteSelect/WriteData outputs one cycle later.

module rf_write_arbiter #(
  parameter int N     = 8,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Req0,
  input  logic             Req1,
  input  logic [AW-1:0]    Addr0,
  input  logic [AW-1:0]    Addr1,
  input  logic [N-1:0]     Data0,
  input  logic [N-1:0]     Data1,
  output logic             Gnt0,
  output logic             Gnt1,
  input  logic             ClearReq,
  output logic             Busy,
  output logic [DEPTH-1:0] WriteSelect,
  output logic [N-1:0]     WriteData
);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam logic [AW-1:0] LAST_ROW = AW'(DEPTH - 1);

  state_t        state;
  logic [AW-1:0] clr_cnt;
  // rr_prio names the requester that wins the next contested cycle.
  logic          rr_prio;
  logic          run_ok;
  logic          gnt0;
  logic          gnt1;

  // An address outside the file decodes to no row rather than an aliased one.
  function automatic logic [DEPTH-1:0] onehot(input logic [AW-1:0] a);
    logic [DEPTH-1:0] v;
    v = '0;
    if (int'(a) < DEPTH) v[a] = 1'b1;
    return v;
  endfunction

  // Grants are possible only in RUN, outside reset, when no clear is requested.
  assign run_ok = !RST && (state == RUN) && !ClearReq;

  // Combinational grant: a lone requester wins, and a tie goes to rr_prio.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (run_ok) begin
      if (Req0 && Req1) begin
        gnt0 = !rr_prio;
        gnt1 = rr_prio;
      end else begin
        gnt0 = Req0;
        gnt1 = Req1;
      end
    end
  end

  assign Gnt0 = gnt0;
  assign Gnt1 = gnt1;
  assign Busy = (state == CLEAR) || RST;

  // Main state machine. It sequences the sweep and registers the selected write.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= CLEAR;
      clr_cnt     <= '0;
      WriteSelect <= '0;
      WriteData   <= '0;
      rr_prio     <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          WriteSelect <= onehot(clr_cnt);
          WriteData   <= '0;
          if (clr_cnt == LAST_ROW) begin
            clr_cnt <= '0;
            state   <= RUN;
          end else begin
            clr_cnt <= clr_cnt + AW'(1);
          end
        end
        RUN: begin
          if (ClearReq) begin
            state       <= CLEAR;
            clr_cnt     <= '0;
            WriteSelect <= '0;
          end else if (gnt0) begin
            WriteSelect <= onehot(Addr0);
            WriteData   <= Data0;
            rr_prio     <= 1'b1;
          end else if (gnt1) begin
            WriteSelect <= onehot(Addr1);
            WriteData   <= Data1;
            rr_prio     <= 1'b0;
          end else begin
            WriteSelect <= '0;
          end
        end
        default: begin
          state       <= CLEAR;
          clr_cnt     <= '0;
          WriteSelect <= '0;
        end
      endcase
    end
  end

  // The two grants are mutually exclusive.
  a_single_grant : assert property (@(posedge CLK) !(Gnt0 && Gnt1));
  // The register file must never see two rows enabled together.
  a_onehot_sel : assert property (@(posedge CLK) $onehot0(WriteSelect));

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter
// Randomized and directed bench for rf_write_arbiter.
// A cycle-level reference model predicts grants and the registered write port.
// A monitor compares the DUT against those predictions one cycle later.

module tb_rf_write_arbiter;

  localparam int N     = 8;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic             CLK = 1'b0;
  logic             RST;
  logic             Req0, Req1;
  logic [AW-1:0]    Addr0, Addr1;
  logic [N-1:0]     Data0, Data1;
  logic             Gnt0, Gnt1;
  logic             ClearReq;
  logic             Busy;
  logic [DEPTH-1:0] WriteSelect;
  logic [N-1:0]     WriteData;

  typedef struct {
    logic [DEPTH-1:0] sel;
    logic [N-1:0]     data;
    logic             busy;
  } exp_t;

  exp_t expQ[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state: sweep in progress, current row, tie winner, held data.
  bit           mBusy = 1'b1;
  int           mIdx  = 0;
  int           mPrio = 0;
  logic [N-1:0] mData = '0;
  int           lose0 = 0;
  int           lose1 = 0;

  rf_write_arbiter #(.N(N), .DEPTH(DEPTH), .AW(AW)) dut (
    .CLK(CLK), .RST(RST),
    .Req0(Req0), .Req1(Req1),
    .Addr0(Addr0), .Addr1(Addr1),
    .Data0(Data0), .Data1(Data1),
    .Gnt0(Gnt0), .Gnt1(Gnt1),
    .ClearReq(ClearReq), .Busy(Busy),
    .WriteSelect(WriteSelect), .WriteData(WriteData)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, check grants, and queue the expected next write port.
  task automatic applyStimulus(input bit rst, input bit clr,
                               input bit r0, input logic [AW-1:0] a0, input logic [N-1:0] d0,
                               input bit r1, input logic [AW-1:0] a1, input logic [N-1:0] d1);
    exp_t e;
    bit   eg0, eg1;
    bit   contested;
    @(negedge CLK);
    RST = rst; ClearReq = clr;
    Req0 = r0; Addr0 = a0; Data0 = d0;
    Req1 = r1; Addr1 = a1; Data1 = d1;
    #1;
    eg0 = 1'b0; eg1 = 1'b0;
    contested = 1'b0;
    if (rst) begin
      mBusy = 1'b1; mIdx = 0; mPrio = 0; mData = '0;
      e = '{sel: '0, data: '0, busy: 1'b1};
    end else if (mBusy) begin
      e = '{sel: DEPTH'(1) << mIdx, data: '0, busy: (mIdx != DEPTH - 1)};
      mData = '0;
      mIdx++;
      if (mIdx == DEPTH) begin
        mBusy = 1'b0;
        mIdx  = 0;
      end
    end else if (clr) begin
      e = '{sel: '0, data: mData, busy: 1'b1};
      mBusy = 1'b1;
      mIdx  = 0;
    end else begin
      contested = r0 && r1;
      if ((contested && mPrio == 0) || (r0 && !r1)) eg0 = 1'b1;
      else if (r1) eg1 = 1'b1;
      if (eg0) begin
        mData = d0; mPrio = 1;
        e = '{sel: DEPTH'(1) << a0, data: d0, busy: 1'b0};
      end else if (eg1) begin
        mData = d1; mPrio = 0;
        e = '{sel: DEPTH'(1) << a1, data: d1, busy: 1'b0};
      end else begin
        e = '{sel: '0, data: mData, busy: 1'b0};
      end
    end
    checkOutput("grants", {30'd0, Gnt1, Gnt0}, {30'd0, eg1, eg0});
    if (contested) begin
      if (Gnt1) lose0++; else lose0 = 0;
      if (Gnt0) lose1++; else lose1 = 0;
      checkOutput("starve0", lose0, 0 + (lose0 > 1 ? 1 : lose0));
      checkOutput("starve1", lose1, 0 + (lose1 > 1 ? 1 : lose1));
    end else begin
      lose0 = 0; lose1 = 0;
    end
    expQ.push_back(e);
  endtask

  // Monitor: after each edge, pop the prediction and compare the registered outputs.
  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("WriteSelect", WriteSelect, e.sel);
      checkOutput("WriteData", 32'(WriteData), 32'(e.data));
      checkOutput("Busy", {31'd0, Busy}, {31'd0, e.busy});
      checkOutput("selOnehot0", {31'd0, $onehot0(WriteSelect)}, 32'd1);
    end
  end

  // Absolute time limit so the run can never hang.
  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    RST = 1'b1; ClearReq = 1'b0;
    Req0 = 1'b0; Req1 = 1'b0;
    Addr0 = '0; Addr1 = '0; Data0 = '0; Data1 = '0;

    repeat (3) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    // Sweep after reset, with requests and a ClearReq that must all be ignored.
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, i == 7, 1, 3, 8'h11, 1, 4, 8'h22);
    // Both requesters held for four cycles alternate from requester 0.
    repeat (4) applyStimulus(0, 0, 1, 1, 8'h01, 1, 2, 8'h02);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    // Single request, then idle so WriteSelect returns to zero.
    applyStimulus(0, 0, 1, 5, 8'hA5, 0, 0, 0);
    repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    // ClearReq beats a request in the same cycle, followed by a full sweep.
    applyStimulus(0, 1, 0, 0, 0, 1, 9, 8'h99);
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    // Same address from both: the winner goes first and the loser overwrites next.
    repeat (2) applyStimulus(0, 0, 1, 7, 8'h3C, 1, 7, 8'hC3);
    // Reset in the middle of a sweep, at row 10.
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus(0, 0, 1, 6, 8'h66, 0, 0, 0);
    // Random traffic with occasional clears and resets.
    for (int i = 0; i < 1000; i++) begin
      applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 59) == 0,
                    $urandom_range(0, 1) == 1, AW'($urandom_range(0, DEPTH - 1)), N'($urandom),
                    $urandom_range(0, 1) == 1, AW'($urandom_range(0, DEPTH - 1)), N'($urandom));
    end
    @(posedge CLK);
    #2;
    checkOutput("queueDrained", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
